// File: rtl/gpio_ctrl_edge_detect.sv
// GPIO input front-end: pad synchronisers, per-pin debounce, edge classification
// and per-bank event pulses for the interrupt status register.
module gpio_ctrl_edge_detect #(
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned PINS_PER_BANK = 8,
  parameter int unsigned DEBOUNCE_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_BANKS*PINS_PER_BANK-1:0]   gpio_in,
  input  logic [NUM_BANKS*PINS_PER_BANK-1:0]   pin_intr_en,
  input  logic [2*NUM_BANKS*PINS_PER_BANK-1:0] edge_mode,
  input  logic [DEBOUNCE_W-1:0]                debounce_cycles,
  output logic [NUM_BANKS*PINS_PER_BANK-1:0]   gpio_filtered,
  output logic [NUM_BANKS-1:0]                 edge_detected
);

  localparam int unsigned NP = NUM_BANKS * PINS_PER_BANK;

  logic [NP-1:0]         s1;
  logic [NP-1:0]         s2;
  logic [1:0]            settle_cnt;
  logic                  settle_done;
  logic [NP-1:0]         stable;
  logic [NP-1:0]         stable_nxt;
  logic [DEBOUNCE_W-1:0] cnt     [NP];
  logic [DEBOUNCE_W-1:0] cnt_nxt [NP];
  logic [NP-1:0]         chg;
  logic [NP-1:0]         mode_rise;
  logic [NP-1:0]         mode_fall;
  logic [NP-1:0]         pin_evt;
  logic [NP-1:0]         evt_nxt;
  logic [NUM_BANKS-1:0]  bank_evt;

  assign settle_done   = (settle_cnt == 2'd3);
  assign gpio_filtered = stable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1            <= '0;
      s2            <= '0;
      settle_cnt    <= '0;
      stable        <= '0;
      pin_evt       <= '0;
      edge_detected <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1            <= gpio_in;
      s2            <= s1;
      if (!settle_done) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      stable        <= stable_nxt;
      pin_evt       <= evt_nxt;
      edge_detected <= bank_evt;
      for (int unsigned i = 0; i < NP; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      mode_rise[p] = edge_mode[2*p];
      mode_fall[p] = edge_mode[2*p+1];
    end
  end

  // Until settle completes, stable simply follows s2 so a pin already high at
  // reset release is absorbed without being seen as a rising edge.
  always_comb begin
    stable_nxt = stable;
    chg        = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      cnt_nxt[p] = '0;
      if (!settle_done) begin
        stable_nxt[p] = s2[p];
      end else if (s2[p] == stable[p]) begin
        cnt_nxt[p] = '0;
      end else if (cnt[p] >= debounce_cycles) begin
        stable_nxt[p] = s2[p];
        chg[p]        = 1'b1;
      end else if (cnt[p] == '1) begin
        cnt_nxt[p] = cnt[p];
      end else begin
        cnt_nxt[p] = cnt[p] + 1'b1;
      end
    end
  end

  always_comb begin
    evt_nxt = chg & ((s2 & mode_rise) | (~s2 & mode_fall)) & pin_intr_en;
  end

  always_comb begin
    bank_evt = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_evt[b] = |pin_evt[b*PINS_PER_BANK +: PINS_PER_BANK];
    end
  end

endmodule

// File: tb/tb_gpio_ctrl_edge_detect.sv
// Bench for gpio_ctrl_edge_detect: expected bank pulses are queued with their
// due cycle and matched against edge_detected every cycle.
module tb_gpio_ctrl_edge_detect;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic [31:0] pin_intr_en;
  logic [63:0] edge_mode;
  logic [7:0]  debounce_cycles;
  logic [31:0] gpio_filtered;
  logic [3:0]  edge_detected;

  typedef struct {
    int unsigned at;
    logic [3:0]  mask;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  gpio_ctrl_edge_detect #(
    .NUM_BANKS     (4),
    .PINS_PER_BANK (8),
    .DEBOUNCE_W    (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gpio_in         (gpio_in),
    .pin_intr_en     (pin_intr_en),
    .edge_mode       (edge_mode),
    .debounce_cycles (debounce_cycles),
    .gpio_filtered   (gpio_filtered),
    .edge_detected   (edge_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].at == cyc) begin
        check("edge_pulse", {28'd0, edge_detected}, {28'd0, sb[0].mask});
        void'(sb.pop_front());
      end else begin
        check("idle_edge", {28'd0, edge_detected}, 32'd0);
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned at, input logic [3:0] mask);
    exp_t e;
    e.at   = at;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic set_mode(input int pin, input logic [1:0] m);
    edge_mode[2*pin +: 2] = m;
  endtask

  initial begin
    rst_n           = 1'b0;
    gpio_in         = 32'hFFFF_FFFF;
    pin_intr_en     = 32'hFFFF_FFFF;
    edge_mode       = '1;
    debounce_cycles = 8'd0;

    // 1: reset with all pins high, no false rising edge on release
    wait_edges(2);
    check("rst_filt", gpio_filtered, 32'd0);
    check("rst_edge", {28'd0, edge_detected}, 32'd0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    wait_edges(3);
    check("settle_filt", gpio_filtered, 32'hFFFF_FFFF);
    wait_edges(4);

    pin_intr_en = '0;
    gpio_in     = '0;
    wait_edges(6);
    check("clr_filt", gpio_filtered, 32'd0);

    // 2: pin 9 rise with N=0; fall silent under mode 01, pulses under 11
    edge_mode = '0;
    set_mode(9, 2'b01);
    pin_intr_en = 32'h0000_0200;
    wait_edges(2);
    gpio_in[9] = 1'b1;
    push_exp(cyc + 4, 4'b0010);
    wait_edges(8);
    check("p9_rise_filt", gpio_filtered, 32'h0000_0200);
    gpio_in[9] = 1'b0;
    wait_edges(8);
    check("p9_fall_filt", gpio_filtered, 32'd0);
    set_mode(9, 2'b11);
    wait_edges(1);
    gpio_in[9] = 1'b1;
    push_exp(cyc + 4, 4'b0010);
    wait_edges(8);
    gpio_in[9] = 1'b0;
    push_exp(cyc + 4, 4'b0010);
    wait_edges(8);

    // 3: N=4, 4-cycle glitch filtered, 5-cycle level accepted
    debounce_cycles = 8'd4;
    edge_mode = '0;
    set_mode(0, 2'b01);
    pin_intr_en = 32'h0000_0001;
    wait_edges(2);
    gpio_in[0] = 1'b1;
    wait_edges(4);
    gpio_in[0] = 1'b0;
    wait_edges(10);
    check("glitch_filt", gpio_filtered, 32'd0);
    gpio_in[0] = 1'b1;
    push_exp(cyc + 8, 4'b0001);
    wait_edges(5);
    gpio_in[0] = 1'b0;
    wait_edges(3);
    check("held5_filt", gpio_filtered, 32'h0000_0001);
    wait_edges(10);
    check("held5_fall_filt", gpio_filtered, 32'd0);

    // 4: two pins of bank 0 together give one pulse; disabled pin 16 only tracks
    debounce_cycles = 8'd0;
    edge_mode = '0;
    set_mode(0, 2'b01);
    set_mode(7, 2'b01);
    set_mode(16, 2'b11);
    pin_intr_en = 32'h0000_0081;
    wait_edges(2);
    gpio_in[0] = 1'b1;
    gpio_in[7] = 1'b1;
    push_exp(cyc + 4, 4'b0001);
    wait_edges(6);
    check("pair_filt", gpio_filtered, 32'h0000_0081);
    gpio_in[16] = 1'b1;
    wait_edges(4);
    check("p16_hi_filt", gpio_filtered, 32'h0001_0081);
    gpio_in[16] = 1'b0;
    wait_edges(4);
    check("p16_lo_filt", gpio_filtered, 32'h0000_0081);

    // 5: one-cycle reset while pin 0 is mid-debounce (N=10, counter at 6)
    gpio_in[0] = 1'b0;
    wait_edges(4);
    debounce_cycles = 8'd10;
    wait_edges(1);
    gpio_in[0] = 1'b1;
    wait_edges(8);
    check("mid_deb_filt", gpio_filtered, 32'h0000_0080);
    rst_n = 1'b0;
    wait_edges(1);
    check("mid_rst_filt", gpio_filtered, 32'd0);
    check("mid_rst_edge", {28'd0, edge_detected}, 32'd0);
    rst_n = 1'b1;
    wait_edges(3);
    check("resettle_filt", gpio_filtered, 32'h0000_0081);
    wait_edges(16);

    // 6: lowering N from 10 to 2 with counter at 5 completes on the next edge
    gpio_in[0] = 1'b0;
    wait_edges(16);
    check("n_pre_filt", gpio_filtered, 32'h0000_0080);
    gpio_in[0] = 1'b1;
    wait_edges(7);
    check("n_hold_filt", gpio_filtered, 32'h0000_0080);
    debounce_cycles = 8'd2;
    push_exp(cyc + 2, 4'b0001);
    wait_edges(1);
    check("n_drop_filt", gpio_filtered, 32'h0000_0081);
    wait_edges(6);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
